// File: rtl/sonar_scheduler.sv
// Round-robin ultrasonic sensor scheduler.
// Fires one HC-SR04-style sensor at a time, times its echo on a shared
// datapath, converts the high time to centimetres and holds the latest
// distance and status for every sensor until that sensor is measured again.
module sonar_scheduler #(
  parameter int NUM_SENSORS    = 3,
  parameter int DIST_W         = 8,
  parameter int TRIG_CYCLES    = 500,
  parameter int CYCLES_PER_CM  = 2900,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int GAP_CYCLES     = 500000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [NUM_SENSORS-1:0]         echo,
  output logic [NUM_SENSORS-1:0]         trig,
  output logic [NUM_SENSORS*DIST_W-1:0]  distance,
  output logic [NUM_SENSORS-1:0]         valid,
  output logic [NUM_SENSORS-1:0]         timeout,
  output logic                           sample_stb,
  output logic [$clog2(NUM_SENSORS)-1:0] active_idx
);

  localparam int IW        = $clog2(NUM_SENSORS);
  localparam int PHASE_MAX = (TRIG_CYCLES > GAP_CYCLES) ? TRIG_CYCLES : GAP_CYCLES;
  localparam int PW        = $clog2(PHASE_MAX + 1);
  localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW        = $clog2(CYCLES_PER_CM + 1);

  localparam logic [PW-1:0]          TRIG_LAST = PW'(TRIG_CYCLES - 1);
  localparam logic [PW-1:0]          GAP_LAST  = PW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0]          TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0]          CM_LAST   = SW'(CYCLES_PER_CM - 1);
  localparam logic [IW-1:0]          IDX_LAST  = IW'(NUM_SENSORS - 1);
  localparam logic [DIST_W-1:0]      DIST_MAX  = {DIST_W{1'b1}};
  localparam logic [NUM_SENSORS-1:0] TRIG_ONE  = NUM_SENSORS'(1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GAP} state_t;

  state_t                              state;
  logic [NUM_SENSORS-1:0]              echo_meta;
  logic [NUM_SENSORS-1:0]              echo_s;
  logic [NUM_SENSORS-1:0]              echo_d;
  logic [PW-1:0]                       phase_cnt;
  logic [TW-1:0]                       to_cnt;
  logic [SW-1:0]                       sub_cnt;
  logic [DIST_W-1:0]                   cm_cnt;
  logic [NUM_SENSORS-1:0][DIST_W-1:0]  dist_q;
  logic                                cur_echo;
  logic                                cur_prev;
  logic [IW-1:0]                       next_idx;

  assign cur_echo = echo_s[active_idx];
  assign cur_prev = echo_d[active_idx];
  assign next_idx = (active_idx == IDX_LAST) ? '0 : active_idx + IW'(1);
  assign distance = dist_q;

  // Centimetre counter increment that sticks at the all-ones value.
  function automatic logic [DIST_W-1:0] sat_inc(input logic [DIST_W-1:0] v);
    if (v == DIST_MAX) begin
      return v;
    end else begin
      return v + DIST_W'(1);
    end
  endfunction

  // Two-flop echo synchroniser plus a history stage so both edges share one latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_meta <= '0;
      echo_s    <= '0;
      echo_d    <= '0;
    end else begin
      echo_meta <= echo;
      echo_s    <= echo_meta;
      echo_d    <= echo_s;
    end
  end

  // Scheduler FSM: owns trig, the shared timing counters and all per-sensor results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      trig       <= '0;
      dist_q     <= '0;
      valid      <= '0;
      timeout    <= '0;
      sample_stb <= 1'b0;
      active_idx <= '0;
      phase_cnt  <= '0;
      to_cnt     <= '0;
      sub_cnt    <= '0;
      cm_cnt     <= '0;
    end else begin
      sample_stb <= 1'b0;
      case (state)
        IDLE: begin
          trig <= '0;
          if (enable) begin
            state     <= TRIG;
            trig      <= TRIG_ONE << active_idx;
            phase_cnt <= '0;
          end
        end
        TRIG: begin
          if (phase_cnt == TRIG_LAST) begin
            trig   <= '0;
            to_cnt <= '0;
            state  <= WAIT_RISE;
          end else begin
            phase_cnt <= phase_cnt + PW'(1);
          end
        end
        WAIT_RISE: begin
          if (to_cnt == TO_LAST) begin
            dist_q[active_idx]  <= DIST_MAX;
            valid[active_idx]   <= 1'b1;
            timeout[active_idx] <= 1'b1;
            sample_stb          <= 1'b1;
            phase_cnt           <= '0;
            state               <= GAP;
          end else begin
            to_cnt <= to_cnt + TW'(1);
            // A line already high on entry has echo_d set, so it never looks like a rise.
            if (cur_echo && !cur_prev) begin
              state <= MEASURE;
              if (CYCLES_PER_CM == 1) begin
                sub_cnt <= '0;
                cm_cnt  <= DIST_W'(1);
              end else begin
                sub_cnt <= SW'(1);
                cm_cnt  <= '0;
              end
            end
          end
        end
        MEASURE: begin
          // Falling edge is tested first so it wins over a coincident timeout.
          if (!cur_echo) begin
            dist_q[active_idx]  <= cm_cnt;
            valid[active_idx]   <= 1'b1;
            timeout[active_idx] <= 1'b0;
            sample_stb          <= 1'b1;
            phase_cnt           <= '0;
            state               <= GAP;
          end else if (to_cnt == TO_LAST) begin
            dist_q[active_idx]  <= DIST_MAX;
            valid[active_idx]   <= 1'b1;
            timeout[active_idx] <= 1'b1;
            sample_stb          <= 1'b1;
            phase_cnt           <= '0;
            state               <= GAP;
          end else begin
            to_cnt <= to_cnt + TW'(1);
            if (sub_cnt == CM_LAST) begin
              sub_cnt <= '0;
              cm_cnt  <= sat_inc(cm_cnt);
            end else begin
              sub_cnt <= sub_cnt + SW'(1);
            end
          end
        end
        GAP: begin
          trig <= '0;
          if (phase_cnt == GAP_LAST) begin
            active_idx <= next_idx;
            phase_cnt  <= '0;
            if (enable) begin
              state <= TRIG;
              trig  <= TRIG_ONE << next_idx;
            end else begin
              state <= IDLE;
            end
          end else begin
            phase_cnt <= phase_cnt + PW'(1);
          end
        end
        default: begin
          state <= IDLE;
          trig  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sonar_scheduler.sv
// Self-checking bench for sonar_scheduler: directed slots plus randomized
// echo delays/widths, checked against a slot-level arithmetic model.
module tb_sonar_scheduler;

  localparam int N        = 3;
  localparam int DW       = 8;
  localparam int TRIG_C   = 4;
  localparam int CPC      = 5;
  localparam int TO       = 200;
  localparam int GAP      = 10;
  // two synchroniser flops plus the registered decision edge
  localparam int SYNC_LAT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [N-1:0]  echo;
  logic [N-1:0]  trig;
  logic [N*DW-1:0] distance;
  logic [N-1:0]  valid;
  logic [N-1:0]  timeout;
  logic          sample_stb;
  logic [1:0]    active_idx;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int exp_dist [N];
  bit exp_valid [N];
  bit exp_to [N];
  int exp_idx;

  always #5 clk = ~clk;

  sonar_scheduler #(
    .NUM_SENSORS(N), .DIST_W(DW), .TRIG_CYCLES(TRIG_C),
    .CYCLES_PER_CM(CPC), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .echo(echo), .trig(trig),
    .distance(distance), .valid(valid), .timeout(timeout),
    .sample_stb(sample_stb), .active_idx(active_idx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slot outcome from the rules: completion edge index after WAIT_RISE entry.
  function automatic void predict(input int dly, input int wid, input bit stuck,
                                  output int stb_k, output bit is_to, output int cm);
    int f;
    f = dly + wid + SYNC_LAT;
    if (stuck || wid == 0 || dly + SYNC_LAT >= TO || f > TO) begin
      stb_k = TO; is_to = 1'b1; cm = (1 << DW) - 1;
    end else begin
      stb_k = f; is_to = 1'b0; cm = wid / CPC;
      if (cm > (1 << DW) - 1) cm = (1 << DW) - 1;
    end
  endfunction

  function automatic logic [31:0] dist_vec();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(exp_dist[i]);
    return v;
  endfunction

  function automatic logic [31:0] bit_vec(input bit which_to);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = which_to ? exp_to[i] : exp_valid[i];
    return v;
  endfunction

  task automatic check_results(input string tag);
    check({tag, "_distance"}, 32'(distance), dist_vec());
    check({tag, "_valid"}, 32'(valid), bit_vec(1'b0));
    check({tag, "_timeout"}, 32'(timeout), bit_vec(1'b1));
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      exp_dist[i] = 0; exp_valid[i] = 1'b0; exp_to[i] = 1'b0;
    end
    exp_idx = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_trig"}, 32'(trig), 32'd0);
    check({tag, "_distance"}, 32'(distance), 32'd0);
    check({tag, "_valid_to"}, 32'({valid, timeout}), 32'd0);
    check({tag, "_stb_idx"}, 32'({sample_stb, active_idx}), 32'd0);
  endtask

  // One complete slot for sensor s; starts at a negedge, ends at a negedge.
  task automatic run_slot(input int s, input int dly, input int wid, input bit stuck,
                          input bit noise, input int drop_k, input bit expect_next,
                          input logic [N-1:0] pre_echo);
    int k, tl, g, stb_k, cm, seen_k;
    bit is_to, multi, done;
    logic [N-1:0] oh;
    predict(dly, wid, stuck, stb_k, is_to, cm);
    oh = '0;
    oh[s] = 1'b1;
    multi = 1'b0;
    if (stuck) echo[s] = 1'b1;
    k = 0;
    while (trig === '0 && k < 40) begin
      @(negedge clk); k++;
    end
    check("trig_select", 32'(trig), 32'(oh));
    check("active_idx", 32'(active_idx), exp_idx);
    tl = 0;
    while (trig[s] === 1'b1 && tl < 40) begin
      if ($countones(trig) > 1) multi = 1'b1;
      @(negedge clk); tl++;
    end
    check("trig_len", tl, TRIG_C);
    k = 0; seen_k = -1; done = 1'b0;
    while (!done && k <= TO + 20) begin
      if ($countones(trig) > 1) multi = 1'b1;
      if (sample_stb === 1'b1) begin
        seen_k = k; done = 1'b1;
      end else begin
        for (int i = 0; i < N; i++)
          if (i == s) echo[i] = stuck || (k >= dly && k < dly + wid);
          else echo[i] = noise && (((k + 3 * i) % 9) < 4);
        if (k == drop_k) enable = 1'b0;
        @(negedge clk); k++;
      end
    end
    echo = pre_echo;
    check("stb_time", seen_k, stb_k);
    exp_dist[s] = cm; exp_valid[s] = 1'b1; exp_to[s] = is_to;
    exp_idx = (exp_idx + 1) % N;
    check_results("slot");
    check("trig_single", 32'(multi), 32'd0);
    @(negedge clk);
    check("stb_pulse", 32'(sample_stb), 32'd0);
    g = 1;
    if (expect_next) begin
      while (trig === '0 && g < 40) begin
        @(negedge clk); g++;
      end
      check("gap_len", g, GAP);
    end else begin
      repeat (GAP + 5) @(negedge clk);
      check("idle_trig", 32'(trig), 32'd0);
      check("idle_idx", 32'(active_idx), exp_idx);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int stb_seen;
    int tw;
    rst = 1'b1; enable = 1'b0; echo = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("disabled_idle", 32'(trig), 32'd0);
    enable = 1'b1;

    // basic 50-cycle echo, then rotation with widths 24 / 1500 / 5
    run_slot(0, 20, 50, 1'b0, 1'b0, -1, 1'b1, '0);
    run_slot(1, 10, 24, 1'b0, 1'b0, -1, 1'b1, '0);
    run_slot(2, 20, 1500, 1'b0, 1'b0, -1, 1'b1, '0);
    run_slot(0, 10, 5, 1'b0, 1'b0, -1, 1'b1, '0);

    // sensor 1 silent, later answers with a 50-cycle echo
    run_slot(1, 0, 0, 1'b0, 1'b0, -1, 1'b1, '0);
    run_slot(2, $urandom_range(0, 40), $urandom_range(1, 150), 1'b0, 1'b0, -1, 1'b1, '0);
    run_slot(0, $urandom_range(0, 40), $urandom_range(1, 150), 1'b0, 1'b0, -1, 1'b1, '0);
    run_slot(1, 20, 50, 1'b0, 1'b0, -1, 1'b1, '0);

    // sensor 0 echo stuck high from the previous gap, noise on the others
    run_slot(2, $urandom_range(0, 40), $urandom_range(1, 150), 1'b0, 1'b0, -1, 1'b1, 3'b001);
    run_slot(0, 0, 0, 1'b1, 1'b1, -1, 1'b1, '0);

    // drop enable during sensor 0's measurement, then resume at sensor 1
    run_slot(1, $urandom_range(0, 40), $urandom_range(1, 150), 1'b0, 1'b1, -1, 1'b1, '0);
    run_slot(2, $urandom_range(0, 40), $urandom_range(1, 150), 1'b0, 1'b1, -1, 1'b1, '0);
    run_slot(0, 15, 40, 1'b0, 1'b0, 23, 1'b0, '0);
    enable = 1'b1;
    run_slot(1, 20, 50, 1'b0, 1'b0, -1, 1'b1, '0);

    // randomized rotation
    for (int i = 0; i < 6; i++) begin
      run_slot(exp_idx, $urandom_range(0, 40), $urandom_range(0, 190), 1'b0,
               1'($urandom_range(0, 1)), -1, 1'b1, '0);
    end

    // fall and timeout on the same edge (normal wins), then one cycle later
    run_slot(exp_idx, 20, 177, 1'b0, 1'b0, -1, 1'b1, '0);
    run_slot(exp_idx, 20, 178, 1'b0, 1'b0, -1, 1'b1, '0);

    // reset while a trigger pulse is high
    #1 rst = 1'b1;
    #1 check_all_zero("rst_trig");
    model_reset();
    stb_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (sample_stb !== 1'b0) stb_seen++;
    end
    check("rst_trig_no_stb", stb_seen, 0);
    rst = 1'b0;

    // restart at sensor 0, reset during its measurement
    tw = 0;
    while (trig === '0 && tw < 40) begin
      @(negedge clk); tw++;
    end
    check("restart_trig", 32'(trig), 32'd1);
    check("restart_idx", 32'(active_idx), 32'd0);
    tw = 0;
    while (trig !== '0 && tw < 40) begin
      @(negedge clk); tw++;
    end
    echo = 3'b001;
    repeat (15) @(negedge clk);
    #1 rst = 1'b1;
    #1 check_all_zero("rst_measure");
    stb_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (sample_stb !== 1'b0) stb_seen++;
    end
    check("rst_measure_no_stb", stb_seen, 0);
    echo = '0;
    rst = 1'b0;
    run_slot(0, 20, 50, 1'b0, 1'b0, -1, 1'b0, '0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
